// File: rtl/mms_pkg.sv
// Shared types and constants for the max/min stream selector family.
package mms_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } mms_state_t;

  localparam logic MODE_MAX = 1'b1;
  localparam logic MODE_MIN = 1'b0;

endpackage

// File: rtl/mms_cmp.sv
// Strict magnitude compare: a_wins is set only when a beats b outright,
// so callers that feed the newer operand on 'a' keep the earlier one on ties.
module mms_cmp
  import mms_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             a_wins
);

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    gt;
  logic                    lt;

  assign a_s = a;
  assign b_s = b;
  assign gt  = (SIGNED != 0) ? (a_s > b_s) : (a > b);
  assign lt  = (SIGNED != 0) ? (a_s < b_s) : (a < b);

  assign a_wins = (mode == MODE_MAX) ? gt : lt;

endmodule

// File: rtl/mms_stream.sv
// Serial max/min reduction over groups of COUNT operands with valid/ready
// on both sides. The result register is held until delivered, and a new
// group may start in the very cycle the previous result is taken.
module mms_stream
  import mms_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int COUNT  = 4,
  parameter  int SIGNED = 0,
  localparam int IW     = $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [IW-1:0]    out_index,
  output logic             busy
);

  // One extra count bit so a power-of-two COUNT never wraps mid-group.
  localparam logic [IW:0] CNT_ONE  = (IW+1)'(1);
  localparam logic [IW:0] CNT_LAST = (IW+1)'(COUNT - 1);

  mms_state_t       state;
  logic [IW:0]      cnt;
  logic [WIDTH-1:0] best;
  logic [IW-1:0]    best_idx;
  logic             mode;
  logic             accept;
  logic             load;
  logic             new_wins;

  // Ready depends only on state and downstream ready, never on in_valid.
  assign in_ready = rst_n && ((state != DONE) || out_ready);
  assign accept   = in_valid && in_ready;
  // In DONE an accept implies out_ready, so the pending result leaves
  // in the same cycle the first operand of the next group arrives.
  assign load     = accept && ((state == IDLE) || (state == DONE));
  assign busy     = (state == ACC);

  mms_cmp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_cmp (
    .a      (in_data),
    .b      (best),
    .mode   (mode),
    .a_wins (new_wins)
  );

  // Running winner and the mode latched from the group's first operand.
  always_ff @(posedge clk) begin
    if (load) begin
      best     <= in_data;
      best_idx <= '0;
      mode     <= select;
    end else if (accept && (state == ACC) && new_wins) begin
      best     <= in_data;
      best_idx <= cnt[IW-1:0];
    end
  end

  // Group sequencing, operand count and the registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_index  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= ACC;
            cnt   <= CNT_ONE;
          end
        end
        ACC: begin
          if (accept) begin
            if (cnt == CNT_LAST) begin
              state      <= DONE;
              cnt        <= '0;
              out_valid  <= 1'b1;
              out_result <= new_wins ? in_data : best;
              out_index  <= new_wins ? cnt[IW-1:0] : best_idx;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              state <= ACC;
              cnt   <= CNT_ONE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mms_stream.sv
// Bench for mms_stream: four instances (COUNT 4 unsigned, COUNT 4 signed,
// COUNT 5 unsigned, COUNT 8 signed) share one input stream. Directed cases
// probe timing on the COUNT 4 pair; a reference scoreboard follows all four.
module tb_mms_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       select;
  logic       out_ready;

  logic       rdy0, rdy1, rdy2, rdy3;
  logic       ov0, ov1, ov2, ov3;
  logic [7:0] res0, res1, res2, res3;
  logic [1:0] ix0, ix1;
  logic [2:0] ix2, ix3;
  logic       busy0, busy1, busy2, busy3;

  logic       rdy [4];
  logic       ov  [4];
  logic [7:0] res [4];
  logic [2:0] ix  [4];

  assign rdy[0] = rdy0; assign rdy[1] = rdy1; assign rdy[2] = rdy2; assign rdy[3] = rdy3;
  assign ov[0]  = ov0;  assign ov[1]  = ov1;  assign ov[2]  = ov2;  assign ov[3]  = ov3;
  assign res[0] = res0; assign res[1] = res1; assign res[2] = res2; assign res[3] = res3;
  assign ix[0]  = {1'b0, ix0}; assign ix[1] = {1'b0, ix1};
  assign ix[2]  = ix2;  assign ix[3]  = ix3;

  mms_stream #(.WIDTH(8), .COUNT(4), .SIGNED(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .select(select), .out_valid(ov0), .out_ready(out_ready), .out_result(res0),
    .out_index(ix0), .busy(busy0));
  mms_stream #(.WIDTH(8), .COUNT(4), .SIGNED(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .select(select), .out_valid(ov1), .out_ready(out_ready), .out_result(res1),
    .out_index(ix1), .busy(busy1));
  mms_stream #(.WIDTH(8), .COUNT(5), .SIGNED(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .select(select), .out_valid(ov2), .out_ready(out_ready), .out_result(res2),
    .out_index(ix2), .busy(busy2));
  mms_stream #(.WIDTH(8), .COUNT(8), .SIGNED(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3), .in_data(in_data),
    .select(select), .out_valid(ov3), .out_ready(out_ready), .out_result(res3),
    .out_index(ix3), .busy(busy3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference scoreboard ----------------
  int         grp_len [4] = '{4, 4, 5, 8};
  bit         grp_sgn [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] gdat    [4][8];
  int         gn      [4];
  logic       gsel    [4];
  bit         exp_v   [4];
  logic [7:0] exp_res [4];
  int         exp_ix  [4];
  bit         held    [4];
  logic [7:0] hres    [4];
  logic [2:0] hix     [4];

  function automatic int as_num(input int d, input logic [7:0] x);
    return grp_sgn[d] ? int'($signed(x)) : int'(x);
  endfunction

  // Winner of the completed group: first strict extreme in arrival order.
  task automatic ref_pick(input int d);
    int bv;
    int v;
    bv = as_num(d, gdat[d][0]);
    exp_res[d] = gdat[d][0];
    exp_ix[d]  = 0;
    for (int i = 1; i < grp_len[d]; i++) begin
      v = as_num(d, gdat[d][i]);
      if (gsel[d] ? (v > bv) : (v < bv)) begin
        bv = v;
        exp_res[d] = gdat[d][i];
        exp_ix[d]  = i;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 4; d++) begin
        gn[d] = 0; exp_v[d] = 1'b0; held[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (held[d]) begin
          check($sformatf("hold_valid_u%0d", d), ov[d], 1);
          check($sformatf("hold_res_u%0d", d), res[d], hres[d]);
          check($sformatf("hold_idx_u%0d", d), ix[d], hix[d]);
        end
        if (ov[d] && out_ready) begin
          check($sformatf("result_expected_u%0d", d), ov[d] && exp_v[d], 1);
          if (exp_v[d]) begin
            check($sformatf("res_u%0d", d), res[d], exp_res[d]);
            check($sformatf("idx_u%0d", d), ix[d], exp_ix[d]);
          end
          exp_v[d] = 1'b0;
        end
        held[d] = ov[d] && !out_ready;
        hres[d] = res[d];
        hix[d]  = ix[d];
        if (in_valid && rdy[d]) begin
          if (gn[d] == 0) gsel[d] = select;
          gdat[d][gn[d]] = in_data;
          gn[d]++;
          if (gn[d] == grp_len[d]) begin
            check($sformatf("overrun_u%0d", d), exp_v[d], 0);
            ref_pick(d);
            exp_v[d] = 1'b1;
            gn[d] = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] d, input logic s, output int waits);
    bit acc;
    in_valid = 1'b1;
    in_data  = d;
    select   = s;
    waits    = 0;
    acc      = 1'b0;
    while (!acc && waits < 200) begin
      @(negedge clk);
      acc = rdy0;
      @(posedge clk);
      #1;
      waits++;
    end
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] e, input logic s);
    int w;
    send(a, s, w); send(b, s, w); send(c, s, w); send(e, s, w);
  endtask

  initial begin
    int w;
    logic [7:0] ga [8];
    logic       gs [8];
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; select = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", ov0, 0);
    check("rst_res", res0, 0);
    check("rst_idx", ix0, 0);
    check("rst_busy", busy0, 0);
    check("rst_ready", rdy0, 0);
    rst_n = 1'b1;

    // Max then min, unsigned and signed views of the same stream.
    send4(8'd3, 8'd200, 8'd17, 8'd200, 1'b1);
    check("max_valid", ov0, 1);
    check("max_res", res0, 200);
    check("max_idx", ix0, 1);
    check("smax_res", res1, 17);
    check("smax_idx", ix1, 2);
    send4(8'd3, 8'd200, 8'd17, 8'd200, 1'b0);
    check("min_res", res0, 3);
    check("min_idx", ix0, 0);
    check("smin_res", res1, 200);
    check("smin_idx", ix1, 1);
    send4(8'hF0, 8'h05, 8'h80, 8'h7F, 1'b1);
    check("sgn_res", res1, 8'h7F);
    check("sgn_idx", ix1, 3);
    check("uns_res", res0, 8'hF0);
    check("uns_idx", ix0, 0);

    // Back-to-back groups, select toggling after the first operand.
    ga = '{8'd10, 8'd50, 8'd30, 8'd50, 8'd10, 8'd50, 8'd5, 8'd5};
    gs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      send(ga[i], gs[i], w);
      check($sformatf("b2b_bubble_%0d", i), w, 1);
      if (i == 3) begin
        check("b2b_a_valid", ov0, 1);
        check("b2b_a_res", res0, 50);
        check("b2b_a_idx", ix0, 1);
      end
      if (i == 4) check("b2b_a_taken", ov0, 0);
    end
    check("b2b_b_valid", ov0, 1);
    check("b2b_b_res", res0, 5);
    check("b2b_b_idx", ix0, 2);

    // Backpressure held for five cycles in DONE.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send4(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    in_valid = 1'b1; in_data = 8'd7; select = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready", rdy0, 0);
      check("bp_valid", ov0, 1);
      check("bp_res", res0, 4);
      check("bp_idx", ix0, 3);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(8'd7, 1'b0, w);
    check("bp_same_cycle", w, 1);
    check("bp_delivered", ov0, 0);
    check("bp_next_busy", busy0, 1);
    send(8'd8, 1'b1, w); send(8'd9, 1'b1, w); send(8'd6, 1'b1, w);
    check("bp_next_res", res0, 6);
    check("bp_next_idx", ix0, 3);

    // Reset in the middle of a group.
    send(8'd1, 1'b1, w); send(8'd2, 1'b1, w);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_valid", ov0, 0);
    check("mid_rst_res", res0, 0);
    check("mid_rst_idx", ix0, 0);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_ready", rdy0, 0);
    check("mid_rst_res_s", res1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send4(8'd9, 8'd9, 8'd9, 8'd9, 1'b0);
    check("post_rst_res", res0, 9);
    check("post_rst_idx", ix0, 0);

    // Random traffic with valid and ready gaps; ties made likely.
    repeat (3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      select    = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) check($sformatf("drain_u%0d", d), exp_v[d], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
